// File: rtl/clk_div_mon_pkg.sv
// rtl/clk_div_mon_pkg.sv - shared state and fault-code definitions for clk_div_monitor
package clk_div_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_LOCKING,
    ST_LOCKED,
    ST_FAULT
  } mon_state_t;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISMATCH = 2'b01;
  localparam logic [1:0] FLT_STUCK    = 2'b10;

endpackage

// File: rtl/half_period_meter.sv
// rtl/half_period_meter.sv - edge detect and saturating half-period counter for a slow clock sampled as data
module half_period_meter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_slow,
  output logic             o_edge,
  output logic [CNT_W-1:0] o_half_len,
  output logic             o_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_s_q;
  logic [CNT_W-1:0] r_run_cnt;

  assign o_edge     = i_slow ^ r_s_q;
  assign o_half_len = r_run_cnt;
  // Saturation means the counter would pass its maximum on this cycle.
  assign o_sat      = !o_edge && (r_run_cnt == CNT_MAX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s_q     <= 1'b0;
      r_run_cnt <= '0;
    end else begin
      r_s_q <= i_slow;
      if (i_clear) begin
        r_run_cnt <= '0;
      end else if (o_edge) begin
        r_run_cnt <= CNT_W'(1);
      end else if (r_run_cnt != CNT_MAX) begin
        r_run_cnt <= r_run_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - checks a divided clock's half-periods against an expected length
// Locks after LOCK_EDGES matching halves, then flags mismatched or stuck periods.
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int LOCK_EDGES = 4,
  parameter int TOL        = 0
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             slow_in,
  input  logic [CNT_W-1:0] exp_half,
  input  logic             clr,
  output logic [CNT_W-1:0] meas_half,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic [1:0]       fault_code
);

  localparam int               MC_W     = $clog2(LOCK_EDGES + 1);
  localparam logic [MC_W-1:0]  LOCK_TGT = MC_W'(LOCK_EDGES);
  localparam logic [CNT_W:0]   TOL_V    = (CNT_W + 1)'(TOL);

  mon_state_t       r_state, w_state_n;
  logic [MC_W-1:0]  r_match_cnt, w_match_n;
  logic [CNT_W-1:0] r_meas_half, w_meas_half_n;
  logic             r_meas_valid, w_meas_valid_n;
  logic [1:0]       r_fault_code, w_fault_n;

  logic             w_edge, w_sat, w_match, w_disable;
  logic [CNT_W-1:0] w_half_len;
  logic [CNT_W:0]   w_diff;

  assign w_disable = (exp_half == '0);

  half_period_meter #(.CNT_W(CNT_W)) u_meter (
    .i_clk      (clk_in),
    .i_rst      (rst),
    .i_clear    (w_disable),
    .i_slow     (slow_in),
    .o_edge     (w_edge),
    .o_half_len (w_half_len),
    .o_sat      (w_sat)
  );

  // One extra bit keeps the absolute difference from wrapping.
  always_comb begin
    w_diff = '0;
    if (w_half_len >= exp_half) w_diff = {1'b0, w_half_len} - {1'b0, exp_half};
    else                        w_diff = {1'b0, exp_half} - {1'b0, w_half_len};
  end

  assign w_match = (w_diff <= TOL_V);

  always_comb begin
    w_state_n      = r_state;
    w_match_n      = r_match_cnt;
    w_meas_half_n  = r_meas_half;
    w_meas_valid_n = 1'b0;
    w_fault_n      = r_fault_code;
    if (w_disable || clr) begin
      w_state_n = ST_IDLE;
      w_match_n = '0;
      w_fault_n = FLT_NONE;
    end else if (w_edge) begin
      if (r_state != ST_IDLE) begin
        w_meas_half_n  = w_half_len;
        w_meas_valid_n = 1'b1;
      end
      case (r_state)
        ST_IDLE: w_state_n = ST_MEASURE;
        ST_MEASURE, ST_LOCKING: begin
          if (w_match) begin
            w_match_n = r_match_cnt + MC_W'(1);
            w_state_n = (r_match_cnt + MC_W'(1) == LOCK_TGT) ? ST_LOCKED : ST_LOCKING;
          end else begin
            w_match_n = '0;
            w_state_n = ST_LOCKING;
          end
        end
        ST_LOCKED: begin
          if (!w_match) begin
            w_state_n = ST_FAULT;
            w_fault_n = FLT_MISMATCH;
          end
        end
        default: w_state_n = r_state;
      endcase
    end else if (w_sat) begin
      // Silence before lock just means the source has not started yet.
      if (r_state == ST_LOCKED) begin
        w_state_n = ST_FAULT;
        w_fault_n = FLT_STUCK;
      end else if (r_state == ST_MEASURE || r_state == ST_LOCKING) begin
        w_state_n = ST_IDLE;
        w_match_n = '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_match_cnt  <= '0;
      r_meas_half  <= '0;
      r_meas_valid <= 1'b0;
      r_fault_code <= FLT_NONE;
    end else begin
      r_state      <= w_state_n;
      r_match_cnt  <= w_match_n;
      r_meas_half  <= w_meas_half_n;
      r_meas_valid <= w_meas_valid_n;
      r_fault_code <= w_fault_n;
    end
  end

  assign meas_half  = r_meas_half;
  assign meas_valid = r_meas_valid;
  assign locked     = (r_state == ST_LOCKED);
  assign err        = (r_state == ST_FAULT);
  assign fault_code = r_fault_code;

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - directed self-checking bench for clk_div_monitor
module tb_clk_div_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       slow;
  logic       clr;
  logic [7:0] exp_half;

  logic [7:0] mh0, mh1;
  logic       mv0, mv1, lk0, lk1, er0, er1;
  logic [1:0] fc0, fc1;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] c_mh, t_mh;
  logic       c_mv, c_lk, c_er, c_mv2, t_lk, t_er;
  logic [1:0] c_fc, t_fc;

  clk_div_monitor #(.CNT_W(8), .LOCK_EDGES(4), .TOL(0)) dut0 (
    .clk_in(clk), .rst(rst), .slow_in(slow), .exp_half(exp_half), .clr(clr),
    .meas_half(mh0), .meas_valid(mv0), .locked(lk0), .err(er0), .fault_code(fc0)
  );

  clk_div_monitor #(.CNT_W(8), .LOCK_EDGES(4), .TOL(1)) dut1 (
    .clk_in(clk), .rst(rst), .slow_in(slow), .exp_half(exp_half), .clr(clr),
    .meas_half(mh1), .meas_valid(mv1), .locked(lk1), .err(er1), .fault_code(fc1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Toggle slow, capture outputs after the sampling edge, then finish an n-cycle half.
  task automatic half(input int n);
    slow = ~slow;
    step();
    c_mh = mh0; c_mv = mv0; c_lk = lk0; c_er = er0; c_fc = fc0;
    t_mh = mh1; t_lk = lk1; t_er = er1; t_fc = fc1;
    step();
    c_mv2 = mv0;
    for (int i = 2; i < n; i++) step();
  endtask

  task automatic pulse_rst();
    rst = 1'b1; slow = 1'b0; clr = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; slow = 1'b0; clr = 1'b0; exp_half = 8'd3;
    step(); step();
    tests_run++; if (mh0 !== 8'd0) begin tests_failed++; $display("FAIL reset_meas_half got=%0d exp=0", mh0); end
    tests_run++; if (mv0 !== 1'b0) begin tests_failed++; $display("FAIL reset_meas_valid got=%0b exp=0", mv0); end
    tests_run++; if (lk0 !== 1'b0) begin tests_failed++; $display("FAIL reset_locked got=%0b exp=0", lk0); end
    tests_run++; if (er0 !== 1'b0) begin tests_failed++; $display("FAIL reset_err got=%0b exp=0", er0); end
    tests_run++; if (fc0 !== 2'b00) begin tests_failed++; $display("FAIL reset_fault_code got=%0b exp=00", fc0); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_lock();
    for (int e = 1; e <= 5; e++) begin
      half(3);
      tests_run++;
      if (c_mv !== (e > 1)) begin tests_failed++; $display("FAIL lock_meas_valid edge=%0d got=%0b exp=%0b", e, c_mv, (e > 1)); end
      if (e > 1) begin
        tests_run++;
        if (c_mh !== 8'd3) begin tests_failed++; $display("FAIL lock_meas_half edge=%0d got=%0d exp=3", e, c_mh); end
      end
      tests_run++;
      if (c_lk !== (e == 5)) begin tests_failed++; $display("FAIL lock_locked edge=%0d got=%0b exp=%0b", e, c_lk, (e == 5)); end
    end
    tests_run++; if (c_er !== 1'b0) begin tests_failed++; $display("FAIL lock_err got=%0b exp=0", c_er); end
    tests_run++; if (c_mv2 !== 1'b0) begin tests_failed++; $display("FAIL lock_valid_one_cycle got=%0b exp=0", c_mv2); end
  endtask

  task automatic test_mismatch();
    half(4);
    tests_run++; if (c_lk !== 1'b1) begin tests_failed++; $display("FAIL mm_still_locked got=%0b exp=1", c_lk); end
    half(3);
    tests_run++; if (c_mh !== 8'd4) begin tests_failed++; $display("FAIL mm_meas_half got=%0d exp=4", c_mh); end
    tests_run++; if (c_lk !== 1'b0) begin tests_failed++; $display("FAIL mm_locked got=%0b exp=0", c_lk); end
    tests_run++; if (c_er !== 1'b1) begin tests_failed++; $display("FAIL mm_err got=%0b exp=1", c_er); end
    tests_run++; if (c_fc !== 2'b01) begin tests_failed++; $display("FAIL mm_fault_code got=%0b exp=01", c_fc); end
    half(3);
    tests_run++; if (c_mv !== 1'b1 || c_er !== 1'b1) begin tests_failed++; $display("FAIL mm_sticky mv=%0b err=%0b exp=1,1", c_mv, c_er); end
    clr = 1'b1; step(); clr = 1'b0;
    tests_run++; if (er0 !== 1'b0 || fc0 !== 2'b00) begin tests_failed++; $display("FAIL mm_clr err=%0b fc=%0b exp=0,00", er0, fc0); end
    for (int e = 1; e <= 5; e++) begin
      half(3);
      tests_run++;
      if (c_lk !== (e == 5)) begin tests_failed++; $display("FAIL mm_relock edge=%0d got=%0b exp=%0b", e, c_lk, (e == 5)); end
    end
  endtask

  task automatic test_stuck();
    for (int i = 0; i < 252; i++) step();
    tests_run++; if (er0 !== 1'b0 || lk0 !== 1'b1) begin tests_failed++; $display("FAIL stuck_early err=%0b locked=%0b exp=0,1", er0, lk0); end
    step();
    tests_run++; if (er0 !== 1'b1) begin tests_failed++; $display("FAIL stuck_err got=%0b exp=1", er0); end
    tests_run++; if (fc0 !== 2'b10) begin tests_failed++; $display("FAIL stuck_fault_code got=%0b exp=10", fc0); end
    tests_run++; if (lk0 !== 1'b0) begin tests_failed++; $display("FAIL stuck_locked got=%0b exp=0", lk0); end
    clr = 1'b1; step(); clr = 1'b0;
    tests_run++; if (er0 !== 1'b0 || fc0 !== 2'b00) begin tests_failed++; $display("FAIL stuck_clr err=%0b fc=%0b exp=0,00", er0, fc0); end
  endtask

  task automatic test_tolerance();
    pulse_rst();
    half(2); half(4); half(2); half(4);
    tests_run++; if (t_lk !== 1'b0) begin tests_failed++; $display("FAIL tol_early_lock got=%0b exp=0", t_lk); end
    half(2);
    tests_run++; if (t_lk !== 1'b1 || t_mh !== 8'd4) begin tests_failed++; $display("FAIL tol_lock locked=%0b mh=%0d exp=1,4", t_lk, t_mh); end
    half(5);
    tests_run++; if (t_lk !== 1'b1) begin tests_failed++; $display("FAIL tol_hold got=%0b exp=1", t_lk); end
    half(3);
    tests_run++; if (t_mh !== 8'd5 || t_er !== 1'b1 || t_fc !== 2'b01) begin tests_failed++; $display("FAIL tol_fault mh=%0d err=%0b fc=%0b exp=5,1,01", t_mh, t_er, t_fc); end
  endtask

  task automatic test_locking_reset();
    pulse_rst();
    half(3); half(3); half(3); half(5);
    half(3);
    tests_run++; if (c_mh !== 8'd5 || c_lk !== 1'b0) begin tests_failed++; $display("FAIL lr_bad_half mh=%0d locked=%0b exp=5,0", c_mh, c_lk); end
    half(3); half(3); half(3);
    tests_run++; if (c_lk !== 1'b0) begin tests_failed++; $display("FAIL lr_third_good got=%0b exp=0", c_lk); end
    half(3);
    tests_run++; if (c_lk !== 1'b1) begin tests_failed++; $display("FAIL lr_fourth_good got=%0b exp=1", c_lk); end
  endtask

  task automatic test_rst_mid();
    rst = 1'b1; slow = ~slow;
    step();
    tests_run++; if (mh0 !== 8'd0 || mv0 !== 1'b0) begin tests_failed++; $display("FAIL rstmid_meas mh=%0d mv=%0b exp=0,0", mh0, mv0); end
    tests_run++; if (lk0 !== 1'b0 || er0 !== 1'b0 || fc0 !== 2'b00) begin tests_failed++; $display("FAIL rstmid_state lk=%0b err=%0b fc=%0b exp=0,0,00", lk0, er0, fc0); end
    rst = 1'b0; slow = 1'b0;
    step();
  endtask

  task automatic test_clr_edge();
    for (int e = 1; e <= 5; e++) half(3);
    tests_run++; if (c_lk !== 1'b1) begin tests_failed++; $display("FAIL ce_prelock got=%0b exp=1", c_lk); end
    clr = 1'b1; slow = ~slow;
    step();
    clr = 1'b0;
    tests_run++; if (mv0 !== 1'b0 || lk0 !== 1'b0) begin tests_failed++; $display("FAIL ce_coincident mv=%0b lk=%0b exp=0,0", mv0, lk0); end
    step();
    tests_run++; if (mv0 !== 1'b0) begin tests_failed++; $display("FAIL ce_no_late_edge got=%0b exp=0", mv0); end
  endtask

  task automatic test_exp_zero();
    for (int e = 1; e <= 5; e++) half(3);
    exp_half = 8'd0;
    for (int e = 1; e <= 4; e++) begin
      half(3);
      tests_run++;
      if (c_lk !== 1'b0 || c_mv !== 1'b0 || c_er !== 1'b0) begin
        tests_failed++; $display("FAIL exp0 edge=%0d lk=%0b mv=%0b err=%0b exp=0,0,0", e, c_lk, c_mv, c_er);
      end
    end
    exp_half = 8'd3;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_mismatch();
    test_stuck();
    test_tolerance();
    test_locking_reset();
    test_rst_mid();
    test_clr_edge();
    test_exp_zero();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
